// File: rtl/sdi_vtg_pkg.sv
// Shared definitions for the SD-SDI (525-line interlaced) video timing
// generator: default raster constants, blanking levels, the YCbCr sample
// type, the 75% colour-bar table and the state encoding.
package sdi_vtg_pkg;

  // Default 525-line NTSC raster
  localparam int DEF_H_ACTIVE     = 720;
  localparam int DEF_H_TOTAL      = 858;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_F2_START     = 266;
  localparam int DEF_F1_START     = 4;
  localparam int DEF_F1_ACT_START = 20;
  localparam int DEF_F1_ACT_END   = 263;
  localparam int DEF_F2_ACT_START = 283;
  localparam int DEF_F2_ACT_END   = 525;
  localparam int DEF_BAR_WIDTH    = 90;

  // 10-bit blanking levels
  localparam logic [9:0] BLANK_Y = 10'd64;
  localparam logic [9:0] BLANK_C = 10'd512;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] cb;
    logic [9:0] cr;
  } ycbcr_t;

  // Two-state raster machine
  typedef logic [0:0] vtg_state_t;
  localparam vtg_state_t IDLE = 1'b0;
  localparam vtg_state_t RUN  = 1'b1;

  // 75% colour bars, index 0 (white) to 7 (black)
  function automatic ycbcr_t bar_colour(input logic [2:0] idx);
    ycbcr_t c;
    case (idx)
      3'd0:    c = '{y: 10'd721, cb: 10'd512, cr: 10'd512};
      3'd1:    c = '{y: 10'd646, cb: 10'd176, cr: 10'd567};
      3'd2:    c = '{y: 10'd525, cb: 10'd625, cr: 10'd176};
      3'd3:    c = '{y: 10'd450, cb: 10'd289, cr: 10'd231};
      3'd4:    c = '{y: 10'd335, cb: 10'd735, cr: 10'd793};
      3'd5:    c = '{y: 10'd260, cb: 10'd399, cr: 10'd848};
      3'd6:    c = '{y: 10'd139, cb: 10'd848, cr: 10'd457};
      default: c = '{y: 10'd64,  cb: 10'd512, cr: 10'd512};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sdi_vtg_colorbar_rom.sv
// Colour-bar lookup: bar index in, registered YCbCr sample out. The output
// register advances on the sample strobe so it lines up with the timing
// outputs of the generator.
module sdi_vtg_colorbar_rom
  import sdi_vtg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [2:0] bar_idx,
  output ycbcr_t     colour
);

  // Register the table entry for the bar under the current sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      colour <= '{y: BLANK_Y, cb: BLANK_C, cr: BLANK_C};
    end else if (ce) begin
      colour <= bar_colour(bar_idx);
    end
  end

endmodule

// File: rtl/sdi_video_timing_gen.sv
// 525-line interlaced raster timing and 4:2:2 10-bit test pattern for the
// native video input of the SDI transmitter. Advances only on vid_ce.
// Optional feature macro: SDI_VTG_COLORBARS_EN (75% colour bars on active
// picture; without it active picture is flat black).
module sdi_video_timing_gen
  import sdi_vtg_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int F2_START     = DEF_F2_START,
  parameter int F1_START     = DEF_F1_START,
  parameter int F1_ACT_START = DEF_F1_ACT_START,
  parameter int F1_ACT_END   = DEF_F1_ACT_END,
  parameter int F2_ACT_START = DEF_F2_ACT_START,
  parameter int F2_ACT_END   = DEF_F2_ACT_END,
  parameter int BAR_WIDTH    = DEF_BAR_WIDTH
) (
  input  logic        sdi_tx_clk,
  input  logic        sdi_tx_rst_n,
  input  logic        vid_ce,
  input  logic        gen_en,
  output logic        VID_IO_OUT_active_video,
  output logic [59:0] VID_IO_OUT_data,
  output logic        VID_IO_OUT_field,
  output logic        VID_IO_OUT_hblank,
  output logic        VID_IO_OUT_vblank,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_line,
  output logic        frame_start,
  output logic        running
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL);
  localparam logic [9:0] F2_S   = 10'(F2_START);
  localparam logic [9:0] F1_S   = 10'(F1_START);
  localparam logic [9:0] F1A_S  = 10'(F1_ACT_START);
  localparam logic [9:0] F1A_E  = 10'(F1_ACT_END);
  localparam logic [9:0] F2A_S  = 10'(F2_ACT_START);
  localparam logic [9:0] F2A_E  = 10'(F2_ACT_END);

  vtg_state_t state;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;
  logic       hblank_d;
  logic       vblank_d;
  logic       field_d;

  assign h_end    = (h_cnt == H_LAST);
  assign v_end    = (v_cnt == V_LAST);
  assign hblank_d = (h_cnt >= H_ACT);
  assign vblank_d = !(((v_cnt >= F1A_S) && (v_cnt <= F1A_E)) ||
                      ((v_cnt >= F2A_S) && (v_cnt <= F2A_E)));
  assign field_d  = (v_cnt >= F2_S) || (v_cnt < F1_S);

  // Raster state machine; gen_en is only honoured at the frame end so a
  // started frame always runs to completion
  always_ff @(posedge sdi_tx_clk) begin
    if (!sdi_tx_rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= 10'd1;
    end else if (vid_ce) begin
      if (state == IDLE) begin
        h_cnt <= '0;
        v_cnt <= 10'd1;
        if (gen_en) begin
          state <= RUN;
        end
      end else if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? 10'd1 : v_cnt + 10'd1;
        if (v_end && !gen_en) begin
          state <= IDLE;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Timing outputs describe the counters at the previous strobe; frame_start
  // is cleared every clock so it stays a single-clock pulse
  always_ff @(posedge sdi_tx_clk) begin
    if (!sdi_tx_rst_n) begin
      VID_IO_OUT_active_video <= 1'b0;
      VID_IO_OUT_hblank       <= 1'b1;
      VID_IO_OUT_vblank       <= 1'b1;
      VID_IO_OUT_field        <= 1'b0;
      h_pos                   <= '0;
      v_line                  <= 10'd1;
      frame_start             <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (vid_ce) begin
        if (state == RUN) begin
          VID_IO_OUT_active_video <= !hblank_d && !vblank_d;
          VID_IO_OUT_hblank       <= hblank_d;
          VID_IO_OUT_vblank       <= vblank_d;
          VID_IO_OUT_field        <= field_d;
          h_pos                   <= h_cnt;
          v_line                  <= v_cnt;
          frame_start             <= (h_cnt == 10'd0) && (v_cnt == 10'd1);
        end else begin
          VID_IO_OUT_active_video <= 1'b0;
          VID_IO_OUT_hblank       <= 1'b1;
          VID_IO_OUT_vblank       <= 1'b1;
          VID_IO_OUT_field        <= 1'b0;
          h_pos                   <= '0;
          v_line                  <= 10'd1;
        end
      end
    end
  end

  assign running = (state == RUN);

`ifdef SDI_VTG_COLORBARS_EN
  localparam int SUB_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAR_WIDTH - 1);

  logic [SUB_W-1:0] bar_sub;
  logic [2:0]       bar_idx;
  logic             chroma_odd;
  ycbcr_t           bar_q;

  // Bar position follows h without a divider; restarts on white every line
  always_ff @(posedge sdi_tx_clk) begin
    if (!sdi_tx_rst_n) begin
      bar_sub <= '0;
      bar_idx <= '0;
    end else if (vid_ce) begin
      if ((state != RUN) || h_end) begin
        bar_sub <= '0;
        bar_idx <= '0;
      end else if (bar_sub == SUB_LAST) begin
        bar_sub <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_sub <= bar_sub + 1'b1;
      end
    end
  end

  sdi_vtg_colorbar_rom u_rom (
    .clk     (sdi_tx_clk),
    .rst_n   (sdi_tx_rst_n),
    .ce      (vid_ce),
    .bar_idx (bar_idx),
    .colour  (bar_q)
  );

  // Chroma phase of the registered sample: Cb on even h, Cr on odd h
  always_ff @(posedge sdi_tx_clk) begin
    if (!sdi_tx_rst_n) begin
      chroma_odd <= 1'b0;
    end else if (vid_ce) begin
      chroma_odd <= (state == RUN) && h_cnt[0];
    end
  end

  assign VID_IO_OUT_data = VID_IO_OUT_active_video ?
                           {40'd0, (chroma_odd ? bar_q.cr : bar_q.cb), bar_q.y} :
                           {40'd0, BLANK_C, BLANK_Y};
`else
  assign VID_IO_OUT_data = {40'd0, BLANK_C, BLANK_Y};
`endif

endmodule

// File: tb/tb_sdi_video_timing_gen.sv
// Bench for sdi_video_timing_gen. A reduced raster instance is compared every
// clock against a sample-index model; a default-raster instance is pinned
// with hand-computed values on the first 20 lines.
`timescale 1ns/1ps
module tb_sdi_video_timing_gen;

  localparam int S_HA = 40, S_HT = 48, S_VT = 25, S_F2 = 14, S_F1 = 4;
  localparam int S_F1AS = 6, S_F1AE = 12, S_F2AS = 17, S_F2AE = 25, S_BW = 5;
  localparam int S_FRAME = S_HT * S_VT;
  localparam logic [59:0] BLANK_DATA = {40'd0, 10'd512, 10'd64};
`ifdef SDI_VTG_COLORBARS_EN
  localparam bit BARS = 1'b1;
`else
  localparam bit BARS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_full_n, vid_ce, gen_en, gen_full;

  logic        s_act, s_hb, s_vb, s_fld, s_fs, s_run;
  logic [59:0] s_data;
  logic [9:0]  s_h, s_v;
  logic        f_act, f_hb, f_vb, f_fld, f_fs, f_run;
  logic [59:0] f_data;
  logic [9:0]  f_h, f_v;

  int total = 0;
  int bad = 0;

  int bar_y  [8] = '{721, 646, 525, 450, 335, 260, 139, 64};
  int bar_cb [8] = '{512, 176, 625, 289, 735, 399, 848, 512};
  int bar_cr [8] = '{512, 567, 176, 231, 793, 848, 457, 512};

  sdi_video_timing_gen #(
    .H_ACTIVE(S_HA), .H_TOTAL(S_HT), .V_TOTAL(S_VT),
    .F2_START(S_F2), .F1_START(S_F1),
    .F1_ACT_START(S_F1AS), .F1_ACT_END(S_F1AE),
    .F2_ACT_START(S_F2AS), .F2_ACT_END(S_F2AE),
    .BAR_WIDTH(S_BW)
  ) dut_small (
    .sdi_tx_clk(clk), .sdi_tx_rst_n(rst_n), .vid_ce(vid_ce), .gen_en(gen_en),
    .VID_IO_OUT_active_video(s_act), .VID_IO_OUT_data(s_data),
    .VID_IO_OUT_field(s_fld), .VID_IO_OUT_hblank(s_hb), .VID_IO_OUT_vblank(s_vb),
    .h_pos(s_h), .v_line(s_v), .frame_start(s_fs), .running(s_run)
  );

  sdi_video_timing_gen dut_full (
    .sdi_tx_clk(clk), .sdi_tx_rst_n(rst_full_n), .vid_ce(vid_ce), .gen_en(gen_full),
    .VID_IO_OUT_active_video(f_act), .VID_IO_OUT_data(f_data),
    .VID_IO_OUT_field(f_fld), .VID_IO_OUT_hblank(f_hb), .VID_IO_OUT_vblank(f_vb),
    .h_pos(f_h), .v_line(f_v), .frame_start(f_fs), .running(f_run)
  );

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue count strobes of vid_ce, one every period clocks, from a negedge
  task automatic applyStimulus(input int period, input int count);
    for (int i = 0; i < count; i++) begin
      vid_ce = 1'b1;
      @(negedge clk);
      vid_ce = 1'b0;
      if (period > 1) repeat (period - 1) @(negedge clk);
    end
  endtask

  // Expected data word for a sample of the reduced raster
  function automatic logic [59:0] pattern(input int hh, input bit act);
    logic [59:0] d;
    int b;
    d = BLANK_DATA;
    b = hh / S_BW;
    if (BARS && act && b < 8)
      d = {40'd0, (hh % 2 == 1) ? 10'(bar_cr[b]) : 10'(bar_cb[b]), 10'(bar_y[b])};
    return d;
  endfunction

  // Reference model: sample index within the frame, decoded arithmetically
  logic        e_act, e_hb, e_vb, e_fld, e_fs, e_run;
  logic [59:0] e_data;
  logic [9:0]  e_h, e_v;
  bit          m_run;
  int          m_s, hh, ll;

  task automatic setIdleExpect();
    e_act = 1'b0; e_hb = 1'b1; e_vb = 1'b1; e_fld = 1'b0;
    e_data = BLANK_DATA; e_h = 10'd0; e_v = 10'd1;
  endtask

  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_run = 1'b0; m_s = 0; e_fs = 1'b0;
      setIdleExpect();
    end else begin
      e_fs = 1'b0;
      if (vid_ce) begin
        if (m_run) begin
          hh = m_s % S_HT;
          ll = m_s / S_HT + 1;
          e_h = 10'(hh);
          e_v = 10'(ll);
          e_hb = (hh >= S_HA);
          e_vb = !((ll >= S_F1AS && ll <= S_F1AE) || (ll >= S_F2AS && ll <= S_F2AE));
          e_fld = (ll >= S_F2) || (ll < S_F1);
          e_act = !e_hb && !e_vb;
          e_data = pattern(hh, e_act);
          e_fs = (m_s == 0);
          if (m_s == S_FRAME - 1 && !gen_en) m_run = 1'b0;
          m_s = (m_s + 1) % S_FRAME;
        end else begin
          setIdleExpect();
          if (gen_en) m_run = 1'b1;
        end
      end
    end
    e_run = m_run;
    #1;
    checkOutput("small_outputs",
                {s_act, s_hb, s_vb, s_fld, s_data, s_h, s_v, s_fs, s_run},
                {e_act, e_hb, e_vb, e_fld, e_data, e_h, e_v, e_fs, e_run});
  end

  // Wait (bounded) for the default-raster instance to show (h, line), then
  // check {active, hblank, vblank, field} and data
  task automatic checkFullAt(input string name, input int h, input int l,
                             input logic [3:0] flags, input logic [59:0] d);
    int n;
    n = 0;
    while (!(f_run && f_h == 10'(h) && f_v == 10'(l)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) checkOutput({name, "_timeout"}, 128'd0, 128'd1);
    else checkOutput(name, {f_act, f_hb, f_vb, f_fld, f_data}, {flags, d});
  endtask

  localparam logic [85:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, BLANK_DATA, 10'd0, 10'd1, 1'b0, 1'b0};

  initial begin
    // watchdog
    #900_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rst_full_n = 1'b0; vid_ce = 1'b0; gen_en = 1'b0; gen_full = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("small_reset", {s_act, s_hb, s_vb, s_fld, s_data, s_h, s_v, s_fs, s_run}, RESET_VEC);
    checkOutput("full_reset",  {f_act, f_hb, f_vb, f_fld, f_data, f_h, f_v, f_fs, f_run}, RESET_VEC);
    rst_n = 1'b1;

    // Idle with gen_en low: nothing moves
    applyStimulus(1, 2000);
    checkOutput("idle_2000", {s_act, s_hb, s_vb, s_fld, s_data, s_h, s_v, s_fs, s_run}, RESET_VEC);

    // Start-up, strobe every 5th clock
    gen_en = 1'b1;
    applyStimulus(1, 1);
    checkOutput("ce1_running", {s_run, s_fs, s_h, s_v}, {1'b1, 1'b0, 10'd0, 10'd1});
    repeat (4) @(negedge clk);
    applyStimulus(1, 1);
    checkOutput("ce2_frame_start", {s_fs, s_h, s_v, s_fld, s_vb, s_hb}, {1'b1, 10'd0, 10'd1, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    checkOutput("frame_start_one_clk", s_fs, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(5, S_FRAME - 1);
    checkOutput("last_sample", {s_h, s_v, s_fs}, {10'd47, 10'd25, 1'b0});
    applyStimulus(1, 1);
    checkOutput("frame_period", {s_fs, s_h, s_v}, {1'b1, 10'd0, 10'd1});
    repeat (4) @(negedge clk);
    applyStimulus(5, S_FRAME);

    // Drop gen_en mid-frame at line 10: frame runs to its end
    applyStimulus(5, 9 * S_HT);
    checkOutput("line10", {s_h, s_v, s_run}, {10'd0, 10'd10, 1'b1});
    gen_en = 1'b0;
    applyStimulus(5, S_FRAME - 1 - 9 * S_HT);
    checkOutput("frame_end_stop", {s_h, s_v, s_run}, {10'd47, 10'd25, 1'b0});
    applyStimulus(1, 1);
    checkOutput("back_to_idle", {s_act, s_hb, s_vb, s_fld, s_data, s_h, s_v, s_fs, s_run}, RESET_VEC);
    applyStimulus(1, 20);

    // Reset mid-frame
    gen_en = 1'b1;
    applyStimulus(1, 300);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_frame_reset", {s_act, s_hb, s_vb, s_fld, s_data, s_h, s_v, s_fs, s_run}, RESET_VEC);
    rst_n = 1'b1;
    applyStimulus(1, 50);

    // Default raster, strobe every clock
    rst_full_n = 1'b1;
    gen_full = 1'b1;
    vid_ce = 1'b1;
    @(negedge clk);
    checkOutput("full_ce1", {f_run, f_fs, f_h, f_v}, {1'b1, 1'b0, 10'd0, 10'd1});
    @(negedge clk);
    checkOutput("full_ce2", {f_run, f_fs, f_h, f_v}, {1'b1, 1'b1, 10'd0, 10'd1});
    checkFullAt("full_857_1",  857, 1,  4'b0111, BLANK_DATA);
    checkFullAt("full_0_2",    0,   2,  4'b0011, BLANK_DATA);
    checkFullAt("full_0_3",    0,   3,  4'b0011, BLANK_DATA);
    checkFullAt("full_0_4",    0,   4,  4'b0010, BLANK_DATA);
    checkFullAt("full_0_19",   0,   19, 4'b0010, BLANK_DATA);
    checkFullAt("full_0_20",   0,   20, 4'b1000, BARS ? {40'd0, 10'd512, 10'd721} : BLANK_DATA);
    checkFullAt("full_1_20",   1,   20, 4'b1000, BARS ? {40'd0, 10'd512, 10'd721} : BLANK_DATA);
    checkFullAt("full_180_20", 180, 20, 4'b1000, BARS ? {40'd0, 10'd625, 10'd525} : BLANK_DATA);
    checkFullAt("full_631_20", 631, 20, 4'b1000, {40'd0, 10'd512, 10'd64});
    checkFullAt("full_719_20", 719, 20, 4'b1000, {40'd0, 10'd512, 10'd64});
    checkFullAt("full_720_20", 720, 20, 4'b0100, BLANK_DATA);
    checkFullAt("full_857_20", 857, 20, 4'b0100, BLANK_DATA);
    vid_ce = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
